// File: rtl/mmss_counter.sv
// mmss_counter: BCD mm:ss stopwatch core with run, pause and per-field adjust modes.
module mmss_counter #(
  parameter int TENS_MAX = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       pause,
  input  logic       adj,
  input  logic       sel,
  input  logic       adj_b,
  input  logic       cnt_dn,
  input  logic       inc_pulse,
  input  logic       dec_pulse,
  output logic [3:0] led_0,
  output logic [3:0] led_1,
  output logic [3:0] led_2,
  output logic [3:0] led_3,
  output logic       rollover,
  output logic       zero
);
  typedef enum logic [1:0] {RUN, PAUSED, ADJUST} mode_t;
  localparam logic [7:0] FMAX = {4'(TENS_MAX), 4'd9};
  mode_t mode;
  logic [7:0] sec, min, sec_nxt, min_nxt, fnew;
  logic run_up, run_dn, btn, fstep, fdn, wrap;
  // One BCD field step, modulo (TENS_MAX+1)*10 in either direction.
  function automatic logic [7:0] step(input logic [7:0] f, input logic dn);
    logic [3:0] t, o;
    t = f[7:4];
    o = f[3:0];
    if (!dn) return (o >= 4'd9) ? ((t >= 4'(TENS_MAX)) ? 8'h00 : {t + 4'd1, 4'd0}) : {t, o + 4'd1};
    return (o == 4'd0) ? ((t == 4'd0) ? FMAX : {t - 4'd1, 4'd9}) : {t, o - 4'd1};
  endfunction
  // Mode is decoded from the live inputs so a tick in the switching cycle sees the new mode.
  always_comb begin
    mode    = adj ? ADJUST : pause ? PAUSED : RUN;
    btn     = inc_pulse | dec_pulse;
    fstep   = (mode != RUN) && (btn ? (inc_pulse ^ dec_pulse) : (mode == ADJUST && tick_2hz));
    fdn     = btn ? dec_pulse : adj_b;
    fnew    = step(sel ? min : sec, fdn);
    run_up  = mode == RUN && tick_1hz && !cnt_dn;
    run_dn  = mode == RUN && tick_1hz && cnt_dn && (sec != 8'h00 || min != 8'h00);
    wrap    = run_up && sec == FMAX && min == FMAX;
    sec_nxt = (run_up || run_dn) ? step(sec, run_dn) : (fstep && !sel) ? fnew : sec;
    min_nxt = ((run_up && sec == FMAX) || (run_dn && sec == 8'h00)) ? step(min, run_dn)
            : (fstep && sel) ? fnew : min;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sec      <= 8'h00;
      min      <= 8'h00;
      rollover <= 1'b0;
      zero     <= 1'b1;
    end else begin
      sec      <= sec_nxt;
      min      <= min_nxt;
      rollover <= wrap;
      zero     <= sec_nxt == 8'h00 && min_nxt == 8'h00;
    end
  end
  assign {led_1, led_0} = sec;
  assign {led_3, led_2} = min;
endmodule

// File: tb/tb_mmss_counter.sv
// tb_mmss_counter: scoreboard bench with an integer minutes/seconds reference model.
module tb_mmss_counter;
  logic clk = 0, rst = 1;
  logic tick_1hz = 0, tick_2hz = 0, pause = 0, adj = 0, sel = 0, adj_b = 0, cnt_dn = 0;
  logic inc_pulse = 0, dec_pulse = 0;
  logic [3:0] led_0, led_1, led_2, led_3;
  logic rollover, zero;
  int tests = 0, fails = 0;
  int ms = 0, ss = 0;
  typedef struct {
    string tag;
    logic [17:0] exp;
  } item_t;
  item_t sb[$];

  mmss_counter #(.TENS_MAX(5)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz), .pause(pause),
    .adj(adj), .sel(sel), .adj_b(adj_b), .cnt_dn(cnt_dn), .inc_pulse(inc_pulse),
    .dec_pulse(dec_pulse), .led_0(led_0), .led_1(led_1), .led_2(led_2), .led_3(led_3),
    .rollover(rollover), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [17:0] got, input logic [17:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] pack(input int m, input int s, input logic r);
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), r, (m == 0 && s == 0)};
  endfunction

  // Advance the reference model for the upcoming edge, queue it, then clock once.
  task automatic cyc(input string tag);
    int f;
    logic r;
    r = 0;
    if (!adj && !pause) begin
      if (tick_1hz && !cnt_dn) begin
        f = (ms * 60 + ss + 1) % 3600;
        r = (f == 0);
        ms = f / 60;
        ss = f % 60;
      end else if (tick_1hz && (ms * 60 + ss) > 0) begin
        f = ms * 60 + ss - 1;
        ms = f / 60;
        ss = f % 60;
      end
    end else begin
      f = sel ? ms : ss;
      if (inc_pulse || dec_pulse) begin
        if (inc_pulse && !dec_pulse) f = (f + 1) % 60;
        if (dec_pulse && !inc_pulse) f = (f + 59) % 60;
      end else if (adj && tick_2hz) f = adj_b ? (f + 59) % 60 : (f + 1) % 60;
      if (sel) ms = f;
      else ss = f;
    end
    sb.push_back('{tag, pack(ms, ss, r)});
    @(posedge clk);
    #3;
    {tick_1hz, tick_2hz, inc_pulse, dec_pulse} = '0;
  endtask

  task automatic load(input logic s, input int n, input logic down);
    adj = 1;
    pause = 0;
    sel = s;
    repeat (n) begin
      if (down) dec_pulse = 1;
      else inc_pulse = 1;
      cyc("load");
    end
  endtask

  always @(posedge clk) begin
    item_t e;
    #2;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, {led_3, led_2, led_1, led_0, rollover, zero}, e.exp);
    end
  end

  initial begin
    #2 rst = 0;
    #1 chk("reset", {led_3, led_2, led_1, led_0, rollover, zero}, {16'h0, 1'b0, 1'b1});
    #19 rst = 1;
    @(posedge clk);
    #3;
    load(1, 12, 0);
    load(0, 34, 0);
    adj = 0;
    cyc("hold_1234");
    #2 rst = 0;
    ms = 0;
    ss = 0;
    #1 chk("async_reset", {led_3, led_2, led_1, led_0, rollover, zero}, {16'h0, 1'b0, 1'b1});
    #2 rst = 1;
    @(posedge clk);
    #3;
    repeat (3) cyc("post_reset");
    load(1, 59, 0);
    load(0, 58, 0);
    adj = 1;
    tick_1hz = 1;
    cnt_dn = 0;
    adj = 0;
    cyc("up_5959");
    cyc("idle");
    tick_1hz = 1;
    cyc("wrap");
    cyc("roll_drop");
    load(0, 2, 0);
    adj = 0;
    cnt_dn = 1;
    repeat (4) begin
      tick_1hz = 1;
      cyc("down_hold");
      cyc("down_idle");
    end
    cnt_dn = 0;
    load(0, 28, 0);
    sel = 1;
    adj_b = 1;
    tick_2hz = 1;
    cyc("adj_wrap");
    tick_1hz = 1;
    cyc("adj_1hz");
    adj_b = 0;
    load(1, 6, 0);
    load(0, 21, 1);
    adj = 0;
    pause = 1;
    sel = 0;
    repeat (10) begin
      tick_1hz = 1;
      cyc("pause_tick");
    end
    inc_pulse = 1;
    cyc("pause_inc");
    inc_pulse = 1;
    dec_pulse = 1;
    cyc("pause_both");
    inc_pulse = 1;
    pause = 0;
    cyc("run_btn");
    load(1, 5, 1);
    load(0, 49, 0);
    inc_pulse = 1;
    tick_2hz = 1;
    adj_b = 0;
    cyc("conflict");
    adj = 0;
    tick_1hz = 1;
    cyc("mode_switch_tick");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
